// File: rtl/branch_redirect_unit_if.sv
// Bundle between the ID/EX boundary, the branch redirect unit and the PC mux.
// master drives stall and ID operands, slave returns redirect/flush (stat_* with BRANCH_REDIRECT_STATS_EN).
interface branch_redirect_unit_if #(
  parameter int XLEN    = 32,
  parameter int JADDR_W = 26
);
  logic               stall;
  logic               id_valid;
  logic               id_branch;
  logic [1:0]         id_jump;
  logic [3:0]         id_aluop;
  logic [XLEN-1:0]    id_rs_val;
  logic [XLEN-1:0]    id_rt_val;
  logic [XLEN-1:0]    id_pc_plus4;
  logic [XLEN-1:0]    id_imm;
  logic [JADDR_W-1:0] id_jaddr;
  logic               redirect;
  logic [XLEN-1:0]    redirect_pc;
  logic               flush_ifid;
  logic               flush_idex;
  logic               ex_taken;
`ifdef BRANCH_REDIRECT_STATS_EN
  logic [31:0]        stat_branches;
  logic [31:0]        stat_taken;
  logic [31:0]        stat_squashed;

  modport master (
    output stall, id_valid, id_branch, id_jump,
    output id_aluop, id_rs_val, id_rt_val,
    output id_pc_plus4, id_imm, id_jaddr,
    input  redirect, redirect_pc,
    input  flush_ifid, flush_idex, ex_taken,
    input  stat_branches, stat_taken, stat_squashed
  );

  modport slave (
    input  stall, id_valid, id_branch, id_jump,
    input  id_aluop, id_rs_val, id_rt_val,
    input  id_pc_plus4, id_imm, id_jaddr,
    output redirect, redirect_pc,
    output flush_ifid, flush_idex, ex_taken,
    output stat_branches, stat_taken, stat_squashed
  );
`else
  modport master (
    output stall, id_valid, id_branch, id_jump,
    output id_aluop, id_rs_val, id_rt_val,
    output id_pc_plus4, id_imm, id_jaddr,
    input  redirect, redirect_pc,
    input  flush_ifid, flush_idex, ex_taken
  );

  modport slave (
    input  stall, id_valid, id_branch, id_jump,
    input  id_aluop, id_rs_val, id_rt_val,
    input  id_pc_plus4, id_imm, id_jaddr,
    output redirect, redirect_pc,
    output flush_ifid, flush_idex, ex_taken
  );
`endif
endinterface

// File: rtl/branch_redirect_unit.sv
// EX-stage branch/jump resolution: registers ID control, issues a PC redirect, squashes 2 wrong-path slots.
// Ports: clk, rst_n, bus (slave: stall, id_* in; redirect, redirect_pc, flush_*, ex_taken out). Option: BRANCH_REDIRECT_STATS_EN.
module branch_redirect_unit #(
  parameter int XLEN    = 32,
  parameter int JADDR_W = 26
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_redirect_unit_if.slave bus
);

  typedef enum logic {
    RUN,
    SQUASH
  } state_t;

  typedef struct packed {
    logic               branch;
    logic [1:0]         jump;
    logic [3:0]         aluop;
    logic [XLEN-1:0]    rs;
    logic [XLEN-1:0]    rt;
    logic [XLEN-1:0]    pc4;
    logic [XLEN-1:0]    imm;
    logic [JADDR_W-1:0] jaddr;
  } id_ex_t;

  id_ex_t          id_d;
  id_ex_t          ex_q;
  logic            ex_valid;
  state_t          state;

  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic            flush_ifid_q;
  logic            flush_idex_q;

  logic            is_jal;
  logic            is_jr;
  logic            cond;
  logic            taken;
  logic            kill;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jal_target;
  logic [XLEN-1:0] target;

  logic signed [XLEN-1:0] rs_s;
  logic signed [XLEN-1:0] rt_s;

  always_comb begin
    id_d = '{
      branch: bus.id_branch,
      jump:   bus.id_jump,
      aluop:  bus.id_aluop,
      rs:     bus.id_rs_val,
      rt:     bus.id_rt_val,
      pc4:    bus.id_pc_plus4,
      imm:    bus.id_imm,
      jaddr:  bus.id_jaddr
    };
  end

  assign rs_s = ex_q.rs;
  assign rt_s = ex_q.rt;

  always_comb begin
    cond = 1'b0;
    case (ex_q.aluop)
      4'b0101: cond = (rs_s == rt_s);
      4'b0110: cond = (rs_s != rt_s);
      4'b0111: cond = (rs_s >= rt_s);
      4'b1000: cond = (rs_s >  rt_s);
      4'b1001: cond = (rs_s <= rt_s);
      4'b1010: cond = (rs_s <  rt_s);
      default: cond = 1'b0;
    endcase
  end

  // jump code 11 decodes as "no jump"
  assign is_jal = (ex_q.jump == 2'b01);
  assign is_jr  = (ex_q.jump == 2'b10);

  assign br_target  = ex_q.pc4 + (ex_q.imm << 2);
  assign jal_target = {
    ex_q.pc4[XLEN-1:XLEN-4],
    ex_q.jaddr,
    2'b00
  };

  always_comb begin
    target = br_target;
    unique case (1'b1)
      is_jal:  target = jal_target;
      is_jr:   target = ex_q.rs;
      default: target = br_target;
    endcase
  end

  assign taken = ex_valid
               & (is_jal | is_jr | (ex_q.branch & cond));

  // anything entering EX behind a taken op is wrong-path
  assign kill = (state == SQUASH) | taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q          <= '0;
      ex_valid      <= 1'b0;
      state         <= RUN;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flush_ifid_q  <= 1'b0;
      flush_idex_q  <= 1'b0;
    end else if (bus.stall) begin
      redirect_q <= 1'b0;
    end else begin
      ex_q     <= id_d;
      ex_valid <= bus.id_valid & ~kill;
      if (state == RUN) begin
        if (taken) begin
          state         <= SQUASH;
          redirect_q    <= 1'b1;
          redirect_pc_q <= target;
          flush_ifid_q  <= 1'b1;
          flush_idex_q  <= 1'b1;
        end else begin
          redirect_q    <= 1'b0;
          flush_ifid_q  <= 1'b0;
          flush_idex_q  <= 1'b0;
        end
      end else begin
        state        <= RUN;
        redirect_q   <= 1'b0;
        flush_ifid_q <= 1'b0;
        flush_idex_q <= 1'b0;
      end
    end
  end

  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.flush_ifid  = flush_ifid_q;
  assign bus.flush_idex  = flush_idex_q;
  assign bus.ex_taken    = taken;

`ifdef BRANCH_REDIRECT_STATS_EN
  logic [31:0] n_br;
  logic [31:0] n_tk;
  logic [31:0] n_sq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_br <= '0;
      n_tk <= '0;
      n_sq <= '0;
    end else if (!bus.stall) begin
      if (ex_valid && ex_q.branch)
        n_br <= n_br + 32'd1;
      if (state == RUN && taken)
        n_tk <= n_tk + 32'd1;
      if (bus.id_valid && kill)
        n_sq <= n_sq + 32'd1;
    end
  end

  assign bus.stat_branches = n_br;
  assign bus.stat_taken    = n_tk;
  assign bus.stat_squashed = n_sq;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed + random bench for branch_redirect_unit against a slot-level reference model.
// Drives the bus master side, checks redirect/flush/ex_taken #1 after every rising edge.
module tb_branch_redirect_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_redirect_unit_if bus ();

  branch_redirect_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        br;
    logic [1:0]  jp;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [25:0] ja;
  } ins_t;

  // model: instruction in EX, its validity, wrong-path slots still to discard
  ins_t        m_ex;
  logic        m_valid;
  int          m_kill;
  logic        m_redirect;
  logic [31:0] m_pc;

  function automatic logic taken_fn(input ins_t i);
    int a;
    int b;
    a = int'(i.rs);
    b = int'(i.rt);
    if (i.jp == 2'b01 || i.jp == 2'b10) return 1'b1;
    if (!i.br) return 1'b0;
    case (i.op)
      4'd5:    return a == b;
      4'd6:    return a != b;
      4'd7:    return a >= b;
      4'd8:    return a > b;
      4'd9:    return a <= b;
      4'd10:   return a < b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] target_fn(input ins_t i);
    if (i.jp == 2'b01)
      return (i.pc4 & 32'hF000_0000) + ({6'd0, i.ja} * 32'd4);
    if (i.jp == 2'b10)
      return i.rs;
    return i.pc4 + i.imm * 32'd4;
  endfunction

  function automatic ins_t mk(
    input logic br, input logic [1:0] jp,
    input logic [3:0] op, input logic [31:0] rs,
    input logic [31:0] rt, input logic [31:0] pc4,
    input logic [31:0] imm, input logic [25:0] ja
  );
    ins_t i;
    i.br = br; i.jp = jp; i.op = op;
    i.rs = rs; i.rt = rt; i.pc4 = pc4;
    i.imm = imm; i.ja = ja;
    return i;
  endfunction

  function automatic ins_t nop();
    return mk(1'b0, 2'b00, 4'd0, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ex       = nop();
    m_valid    = 1'b0;
    m_kill     = 0;
    m_redirect = 1'b0;
    m_pc       = 32'd0;
  endtask

  task automatic check_all();
    logic exp_t;
    exp_t = m_valid && taken_fn(m_ex);
    chk("redirect", 32'(bus.redirect), 32'(m_redirect));
    chk("redirect_pc", bus.redirect_pc, m_pc);
    chk("flush_ifid", 32'(bus.flush_ifid), 32'(m_kill != 0));
    chk("flush_idex", 32'(bus.flush_idex), 32'(m_kill != 0));
    chk("ex_taken", 32'(bus.ex_taken), 32'(exp_t));
  endtask

  // one clock: drive ID, advance model, check after the edge
  task automatic step(input logic st, input logic v, input ins_t i);
    logic t;
    bus.stall       = st;
    bus.id_valid    = v;
    bus.id_branch   = i.br;
    bus.id_jump     = i.jp;
    bus.id_aluop    = i.op;
    bus.id_rs_val   = i.rs;
    bus.id_rt_val   = i.rt;
    bus.id_pc_plus4 = i.pc4;
    bus.id_imm      = i.imm;
    bus.id_jaddr    = i.ja;
    t = m_valid && taken_fn(m_ex);
    if (!st) begin
      m_redirect = t;
      if (t) begin
        m_pc    = target_fn(m_ex);
        m_valid = 1'b0;
        m_kill  = 1;
      end else if (m_kill != 0) begin
        m_valid = 1'b0;
        m_kill--;
      end else begin
        m_valid = v;
      end
      m_ex = i;
    end else begin
      m_redirect = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  ins_t r;

  initial begin
    model_reset();
    bus.stall = 1'b0;
    bus.id_valid = 1'b0;
    bus.id_branch = 1'b0;
    bus.id_jump = 2'b00;
    bus.id_aluop = 4'd0;
    bus.id_rs_val = '0;
    bus.id_rt_val = '0;
    bus.id_pc_plus4 = '0;
    bus.id_imm = '0;
    bus.id_jaddr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // beq taken, bne + jal on wrong path, jr arrives at N+4
    step(0, 1, mk(1, 0, 4'd5, 5, 5, 32'h100, 3, 0));
    chk("beq_ex_taken", 32'(bus.ex_taken), 1);
    chk("beq_no_early", 32'(bus.redirect), 0);
    step(0, 1, mk(1, 0, 4'd6, 1, 2, 32'h104, 9, 0));
    chk("beq_redirect", 32'(bus.redirect), 1);
    chk("beq_pc", bus.redirect_pc, 32'h10C);
    chk("beq_flush", 32'(bus.flush_ifid & bus.flush_idex), 1);
    step(0, 1, mk(0, 1, 4'd0, 0, 0, 32'h108, 0, 26'h55));
    chk("wp_pulse_end", 32'(bus.redirect), 0);
    chk("wp_flush_end", 32'(bus.flush_ifid | bus.flush_idex), 0);
    step(0, 1, mk(0, 2, 4'd0, 32'h2000, 0, 32'h110, 0, 0));
    chk("bne_never", 32'(bus.redirect), 0);
    step(0, 0, nop());
    chk("jr_n4_taken", 32'(bus.ex_taken), 0);
    chk("jr_pc", bus.redirect_pc, 32'h2000);
    chk("jr_redirect", 32'(bus.redirect), 1);
    repeat (2) step(0, 0, nop());

    // signed blt taken, signed bgt not taken
    step(0, 1, mk(1, 0, 4'd10, 32'hFFFF_FFFF, 1, 32'h200, 1, 0));
    step(0, 0, nop());
    chk("blt_pc", bus.redirect_pc, 32'h204);
    repeat (2) step(0, 0, nop());
    step(0, 1, mk(1, 0, 4'd8, 32'hFFFF_FFFF, 1, 32'h300, 1, 0));
    chk("bgt_not_taken", 32'(bus.ex_taken), 0);
    step(0, 0, nop());
    chk("bgt_no_redirect", 32'(bus.redirect), 0);

    // j target, and jump overriding a taken beq
    step(0, 1, mk(0, 1, 4'd0, 0, 0, 32'h4000_0010, 0, 26'h100));
    step(0, 0, nop());
    chk("j_pc", bus.redirect_pc, 32'h4000_0400);
    repeat (2) step(0, 0, nop());
    step(0, 1, mk(1, 1, 4'd5, 5, 5, 32'h1000, 7, 26'h10));
    step(0, 0, nop());
    chk("j_over_br_pc", bus.redirect_pc, 32'h0000_0040);
    repeat (2) step(0, 0, nop());

    // taken beq held under stall for 3 cycles
    step(0, 1, mk(1, 0, 4'd5, 7, 7, 32'h300, 32'hFFFF_FFFF, 0));
    repeat (3) step(1, 0, nop());
    chk("stall_no_redirect", 32'(bus.redirect), 0);
    step(0, 0, nop());
    chk("stall_redirect", 32'(bus.redirect), 1);
    chk("stall_pc", bus.redirect_pc, 32'h2FC);
    step(1, 1, nop());
    chk("stall_sq_flush", 32'(bus.flush_ifid), 1);
    repeat (2) step(0, 0, nop());

    // async reset while in SQUASH
    step(0, 1, mk(0, 2, 4'd0, 32'h3000, 0, 32'h400, 0, 0));
    step(0, 0, nop());
    chk("pre_rst_redirect", 32'(bus.redirect), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, mk(1, 0, 4'd5, 1, 1, 32'h500, 0, 0));
    step(0, 0, nop());
    chk("post_rst_pc", bus.redirect_pc, 32'h500);
    repeat (2) step(0, 0, nop());

    // random traffic
    for (int n = 0; n < 400; n++) begin
      r.br  = 1'($urandom_range(0, 1));
      r.jp  = ($urandom_range(0, 3) == 0)
            ? 2'($urandom_range(0, 3)) : 2'b00;
      r.op  = 4'($urandom_range(0, 15));
      r.rs  = $urandom;
      r.rt  = ($urandom_range(0, 3) == 0) ? r.rs : $urandom;
      r.pc4 = $urandom;
      r.imm = $urandom;
      r.ja  = 26'($urandom);
      step(1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 3) != 0), r);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- EX-stage consumer of the opcode decoder's branch, jump and aluop control outputs.
- Registers ID-stage control and operands, resolves branch conditions and jump targets, and issues a one-cycle PC redirect to the fetch stage.
- Runs a squash FSM that kills the two wrong-path instructions behind a taken branch or jump.
- Sits between the ID/EX boundary and the PC mux.

Parameters:
- XLEN, 32, datapath and PC width
- JADDR_W, 26, jump-address field width; must equal XLEN-6

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  pipeline hold; EX register and FSM freeze
- id_valid  in  1  ID-stage instruction valid
- id_branch  in  1  decoder branch
- id_jump  in  2  decoder jump: 00 none, 01 j/jal, 10 jr, 11 none
- id_aluop  in  4  decoder aluop (branch condition code)
- id_rs_val  in  XLEN  forwarded rs operand
- id_rt_val  in  XLEN  forwarded rt operand
- id_pc_plus4  in  XLEN  PC+4 of the ID instruction
- id_imm  in  XLEN  sign-extended immediate
- id_jaddr  in  JADDR_W  jump-address field
- redirect  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  XLEN  redirect target
- flush_ifid  out  1  kill IF/ID register this cycle
- flush_idex  out  1  kill ID/EX register this cycle
- ex_taken  out  1  combinational: valid EX instruction resolves taken

Behaviour:
- Reset (async, rst_n=0): ex_valid=0, all EX fields=0, state=RUN, redirect=0, redirect_pc=0, flush_ifid=0, flush_idex=0.
- EX register capture: on a clk edge with stall=0, capture all id_* fields. ex_valid is captured as id_valid AND NOT kill.
  - kill=1 when state=SQUASH, or when ex_taken=1 this cycle.
- stall=1: EX register, ex_valid and state all hold. redirect is forced to 0. Resolution is deferred; a taken branch held under stall redirects on the first edge with stall=0.
- Condition, evaluated from EX register when ex_branch=1:
  - aluop 0101 beq: rs==rt
  - aluop 0110 bne: rs!=rt
  - aluop 0111 bge: rs>=rt
  - aluop 1000 bgt: rs>rt
  - aluop 1001 ble: rs<=rt
  - aluop 1010 blt: rs<rt
  - All comparisons are two's-complement signed. Any other aluop = not taken.
- Target calculation:
  - Branch: pc_plus4 + (imm<<2), modulo 2^XLEN (wrap, no trap).
  - jump=01: {pc_plus4[XLEN-1:XLEN-4], jaddr, 2'b00}.
  - jump=10: rs_val.
- Priority: jump (01/10) overrides branch. jump=11 is treated as 00.
- ex_taken = ex_valid AND (jump in {01,10} OR branch condition true).
- FSM states: RUN, SQUASH.
  - RUN -> SQUASH on an edge with stall=0 and ex_taken=1. On the same edge: redirect<=1, redirect_pc<=target, flush_ifid<=1, flush_idex<=1.
  - SQUASH -> RUN on the next edge with stall=0. On that edge redirect, flush_ifid and flush_idex go to 0. The incoming ID instruction is captured with valid=0.
  - SQUASH with stall=1: hold SQUASH, hold flush_* high, redirect=0.
- Latency: ID present in cycle N -> redirect high in cycle N+2, for exactly one cycle. The next correct-path instruction reaches EX no earlier than cycle N+4.
- A taken branch in the wrong-path slot is never resolved, because ex_valid=0.
- Non-taken, non-jump instructions produce no outputs.
- Reset asserted mid-SQUASH: outputs and state clear immediately (async).

Optional Feature:
- Macro: BRANCH_REDIRECT_STATS_EN.
- Defined: adds outputs stat_branches (32), stat_taken (32) and stat_squashed (32), all wrapping counters, reset 0.
  - stat_branches increments on an edge with stall=0, ex_valid=1 and ex_branch=1.
  - stat_taken increments on each redirect assertion edge.
  - stat_squashed increments on each capture where id_valid=1 but kill=1.
- Undefined: those ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- beq, rs=rt=5, pc_plus4=0x100, imm=3 -> redirect=1 exactly in cycle N+2, redirect_pc=0x10C, flush_ifid=flush_idex=1 for one cycle.
- blt, rs=0xFFFFFFFF, rt=1 -> taken (signed); bltu-style unsigned interpretation must not apply. Same operands with bgt -> no redirect.
- j, pc_plus4=0x40000010, jaddr=0x0000100 -> redirect_pc=0x40000400. jr with rs=0x2000 -> redirect_pc=0x2000. Branch=1 together with jump=01 -> jump target wins.
- Taken beq followed by a taken bne on the wrong path -> exactly one redirect pulse; the bne never redirects; next valid EX instruction arrives at N+4.
- Taken beq in EX with stall=1 for 3 cycles -> redirect stays 0; redirect pulses on the first edge after stall falls, with the correct target.
- rst_n=0 asserted in SQUASH -> redirect, flush_* and state clear asynchronously; first instruction after release resolves normally.
